// File: rtl/mc_sequencer.sv
// Multicycle control FSM for the simpleCPU datapath: register enables, mux selects, memory handshake.
// Optional trap state for unknown opcodes is built when SEQ_TRAP_EN is defined.
module mc_sequencer #(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned WCNT_W   = 8
) (
  input  logic       Clk,
  input  logic       Clrn,
  input  logic [5:0] Op,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       MemWrite,
  output logic       IorD,
  output logic       PCEn,
  output logic       IREn,
  output logic       AEn,
  output logic       BEn,
  output logic       ALUOutEn,
  output logic       MDREn,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic [3:0] State,
  output logic       Halted
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_RWB    = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
  localparam logic [3:0] S_ADDIEX = 4'd10;
  localparam logic [3:0] S_ADDIWB = 4'd11;
`ifdef SEQ_TRAP_EN
  localparam logic [3:0] S_TRAP   = 4'd12;
`endif
  localparam logic [3:0] S_HALT   = 4'd15;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  logic [3:0]        state, state_nxt;
  logic [WCNT_W-1:0] wcnt, wcnt_nxt;
  logic              wait_expired;

  // Raw (ungated) decode of the current state
  logic       mem_req, mem_write, iord, pc_en, ir_en, a_en, b_en, aluout_en, mdr_en;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a, halted;
  logic [1:0] alu_src_b, alu_op, pc_src;

  // State and wait-counter registers
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state <= S_FETCH;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // The access that would bring the counter to MAX_WAIT is the last one tolerated
  assign wait_expired = (wcnt == WCNT_W'(MAX_WAIT - 1));

  // Next-state and raw output decode
  always_comb begin
    state_nxt  = state;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    pc_en      = 1'b0;
    ir_en      = 1'b0;
    a_en       = 1'b0;
    b_en       = 1'b0;
    aluout_en  = 1'b0;
    mdr_en     = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    halted     = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_en     = MemReady;
        pc_en     = MemReady;
        if (MemReady)          state_nxt = S_DECODE;
        else if (wait_expired) state_nxt = S_HALT;
      end
      S_DECODE: begin
        a_en      = 1'b1;
        b_en      = 1'b1;
        aluout_en = 1'b1;
        alu_src_b = 2'b11;
        case (Op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_R:         state_nxt = S_EXEC;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_J:         state_nxt = S_JUMP;
          OP_ADDI:      state_nxt = S_ADDIEX;
`ifdef SEQ_TRAP_EN
          default:      state_nxt = S_TRAP;
`else
          default:      state_nxt = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        aluout_en = 1'b1;
        state_nxt = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mdr_en  = MemReady;
        if (MemReady)          state_nxt = S_MEMWB;
        else if (wait_expired) state_nxt = S_HALT;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
        if (MemReady)          state_nxt = S_FETCH;
        else if (wait_expired) state_nxt = S_HALT;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        aluout_en = 1'b1;
        state_nxt = S_RWB;
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_nxt = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        pc_en     = Zero;
        state_nxt = S_FETCH;
      end
      S_JUMP: begin
        pc_src    = 2'b10;
        pc_en     = 1'b1;
        state_nxt = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        aluout_en = 1'b1;
        state_nxt = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        state_nxt = S_FETCH;
      end
`ifdef SEQ_TRAP_EN
      S_TRAP: begin
        pc_src    = 2'b11;
        pc_en     = 1'b1;
        state_nxt = S_FETCH;
      end
`endif
      S_HALT: begin
        halted    = 1'b1;
        state_nxt = S_HALT;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // Count stalled access cycles; any completed access or non-memory state clears it
  always_comb begin
    wcnt_nxt = '0;
    if (mem_req && !MemReady) wcnt_nxt = wcnt + WCNT_W'(1);
  end

  // Everything reads 0 while reset is asserted, so a reset mid-access drops MemReq at once
  assign MemReq   = Clrn & mem_req;
  assign MemWrite = Clrn & mem_write;
  assign IorD     = Clrn & iord;
  assign PCEn     = Clrn & pc_en;
  assign IREn     = Clrn & ir_en;
  assign AEn      = Clrn & a_en;
  assign BEn      = Clrn & b_en;
  assign ALUOutEn = Clrn & aluout_en;
  assign MDREn    = Clrn & mdr_en;
  assign RegWrite = Clrn & reg_write;
  assign RegDst   = Clrn & reg_dst;
  assign MemToReg = Clrn & mem_to_reg;
  assign ALUSrcA  = Clrn & alu_src_a;
  assign ALUSrcB  = {2{Clrn}} & alu_src_b;
  assign ALUOp    = {2{Clrn}} & alu_op;
  assign PCSrc    = {2{Clrn}} & pc_src;
  assign Halted   = Clrn & halted;
  assign State    = state;

endmodule

// File: tb/tb_mc_sequencer.sv
// Randomized bench for mc_sequencer: per-instruction state paths and output sets from a table model.
module tb_mc_sequencer;

  localparam int unsigned MAXW = 15;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  logic       Clk, Clrn, Zero, MemReady;
  logic [5:0] Op;
  logic       MemReq, MemWrite, IorD, PCEn, IREn, AEn, BEn, ALUOutEn, MDREn;
  logic       RegWrite, RegDst, MemToReg, ALUSrcA, Halted;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic [3:0] State;
  logic [19:0] obs;

  int vec_cnt  = 0;
  int miscompares = 0;

  mc_sequencer #(.MAX_WAIT(MAXW), .WCNT_W(8)) dut (
    .Clk(Clk), .Clrn(Clrn), .Op(Op), .Zero(Zero), .MemReady(MemReady),
    .MemReq(MemReq), .MemWrite(MemWrite), .IorD(IorD), .PCEn(PCEn), .IREn(IREn),
    .AEn(AEn), .BEn(BEn), .ALUOutEn(ALUOutEn), .MDREn(MDREn), .RegWrite(RegWrite),
    .RegDst(RegDst), .MemToReg(MemToReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .PCSrc(PCSrc), .State(State), .Halted(Halted)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  assign obs = {MemReq, MemWrite, IorD, PCEn, IREn, AEn, BEn, ALUOutEn, MDREn,
                RegWrite, RegDst, MemToReg, ALUSrcA, ALUSrcB, ALUOp, PCSrc, Halted};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Output set required in each state, written straight from the state descriptions
  function automatic logic [19:0] exp_vec(input logic [3:0] st, input logic rdy, input logic z);
    logic mreq, mwr, iord, pcen, iren, aen, ben, aoen, mdren, rw, rdst, m2r, asa, hlt;
    logic [1:0] asb, aop, psrc;
    {mreq, mwr, iord, pcen, iren, aen, ben, aoen, mdren, rw, rdst, m2r, asa, hlt} = '0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (st)
      4'd0:  begin mreq = 1; asb = 2'b01; pcen = rdy; iren = rdy; end
      4'd1:  begin aen = 1; ben = 1; aoen = 1; asb = 2'b11; end
      4'd2:  begin asa = 1; asb = 2'b10; aoen = 1; end
      4'd3:  begin mreq = 1; iord = 1; mdren = rdy; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin mreq = 1; mwr = 1; iord = 1; end
      4'd6:  begin asa = 1; aop = 2'b10; aoen = 1; end
      4'd7:  begin rw = 1; rdst = 1; end
      4'd8:  begin asa = 1; aop = 2'b01; psrc = 2'b01; pcen = z; end
      4'd9:  begin psrc = 2'b10; pcen = 1; end
      4'd10: begin asa = 1; asb = 2'b10; aoen = 1; end
      4'd11: begin rw = 1; end
      4'd12: begin psrc = 2'b11; pcen = 1; end
      4'd15: begin hlt = 1; end
      default: ;
    endcase
    return {mreq, mwr, iord, pcen, iren, aen, ben, aoen, mdren, rw, rdst, m2r, asa, asb, aop, psrc, hlt};
  endfunction

  // One clock: drive inputs just after the falling edge, check, advance to the next falling edge
  task automatic cyc(input string tag, input logic [3:0] st, input logic rdy, input logic z);
    MemReady = rdy;
    Zero     = z;
    #1;
    check({tag, "_state"}, 32'(State), 32'(st));
    check({tag, "_outs"}, 32'(obs), 32'(exp_vec(st, rdy, z)));
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic do_reset();
    Clrn = 1'b0;
    MemReady = 1'b0;
    #1;
    check("rst_outs", 32'(obs), 32'd0);
    check("rst_state", 32'(State), 32'd0);
    @(negedge Clk);
    @(negedge Clk);
    Clrn = 1'b1;
  endtask

  // Runs one instruction: fw/dw fix the fetch/data wait counts (-1 = random 0..2), zs fixes Zero (-1 = random)
  task automatic run_instr(input logic [5:0] op, input int fw, input int dw, input int zs);
    logic [3:0] path[$];
    int nw;
    logic z;
    path = {4'd0, 4'd1};
    case (op)
      OP_R:    path = {path, 4'd6, 4'd7};
      OP_LW:   path = {path, 4'd2, 4'd3, 4'd4};
      OP_SW:   path = {path, 4'd2, 4'd5};
      OP_BEQ:  path = {path, 4'd8};
      OP_J:    path = {path, 4'd9};
      OP_ADDI: path = {path, 4'd10, 4'd11};
`ifdef SEQ_TRAP_EN
      default: path = {path, 4'd12};
`else
      default: ;
`endif
    endcase
    Op = op;
    foreach (path[i]) begin
      if (path[i] == 4'd0 || path[i] == 4'd3 || path[i] == 4'd5) begin
        nw = (path[i] == 4'd0) ? fw : dw;
        if (nw < 0) nw = int'($urandom_range(0, 2));
        for (int w = 0; w <= nw; w++) begin
          z = (zs < 0) ? 1'($urandom_range(0, 1)) : 1'(zs);
          cyc("instr", path[i], (w == nw), z);
        end
      end else begin
        z = (zs < 0) ? 1'($urandom_range(0, 1)) : 1'(zs);
        cyc("instr", path[i], 1'($urandom_range(0, 1)), z);
      end
    end
  endtask

  logic [5:0] rop;

  initial begin
    Clrn = 1'b0; MemReady = 1'b0; Zero = 1'b0; Op = OP_R;
    @(negedge Clk);
    do_reset();

    // Directed: R with ready tied high, LW with 3 data waits, BEQ both ways, unknown opcode
    run_instr(OP_R, 0, 0, -1);
    run_instr(OP_LW, 0, 3, -1);
    run_instr(OP_BEQ, 0, 0, 1);
    run_instr(OP_BEQ, 0, 0, 0);
    run_instr(OP_J, 0, 0, -1);
    run_instr(OP_SW, 1, 2, -1);
    run_instr(OP_ADDI, 0, 0, -1);
    run_instr(6'b111111, 0, 0, -1);

    // Reset asserted in the middle of a stalled data read
    Op = OP_LW;
    cyc("rmid", 4'd0, 1'b1, 1'b0);
    cyc("rmid", 4'd1, 1'b1, 1'b0);
    cyc("rmid", 4'd2, 1'b1, 1'b0);
    MemReady = 1'b0;
    #1;
    check("rmid_memreq_pre", 32'(MemReq), 32'd1);
    #1;
    Clrn = 1'b0;
    #1;
    check("rmid_memreq_async", 32'(MemReq), 32'd0);
    check("rmid_outs", 32'(obs), 32'd0);
    check("rmid_state", 32'(State), 32'd0);
    @(negedge Clk);
    Clrn = 1'b1;
    #1;
    check("rel_state", 32'(State), 32'd0);
    check("rel_halted", 32'(Halted), 32'd0);
    check("rel_memreq", 32'(MemReq), 32'd1);
    @(negedge Clk);
    run_instr(OP_R, 0, 0, -1);

    // Timeout in FETCH: MAXW stalled cycles lead to HALT, which persists
    do_reset();
    for (int i = 0; i < int'(MAXW); i++) cyc("to", 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc("halt", 4'd15, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    do_reset();

    // Ready arriving on the last tolerated cycle completes normally
    Op = OP_J;
    for (int i = 0; i < int'(MAXW) - 1; i++) cyc("late", 4'd0, 1'b0, 1'b0);
    cyc("late", 4'd0, 1'b1, 1'b0);
    cyc("late", 4'd1, 1'b0, 1'b0);
    cyc("late", 4'd9, 1'b0, 1'b0);

    // Timeout during a store
    Op = OP_SW;
    cyc("tosw", 4'd0, 1'b1, 1'b0);
    cyc("tosw", 4'd1, 1'b1, 1'b0);
    cyc("tosw", 4'd2, 1'b1, 1'b0);
    for (int i = 0; i < int'(MAXW); i++) cyc("tosw", 4'd5, 1'b0, 1'b0);
    cyc("tosw", 4'd15, 1'b1, 1'b0);
    do_reset();

    // Random instruction stream
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 7))
        0: rop = OP_R;
        1: rop = OP_LW;
        2: rop = OP_SW;
        3: rop = OP_BEQ;
        4: rop = OP_J;
        5: rop = OP_ADDI;
        default: rop = 6'($urandom_range(0, 63));
      endcase
      run_instr(rop, -1, -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
